// File: rtl/rv_mc_seq_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories. The sequencer is the master; memories are slaves.
interface rv_mc_seq_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/rv_mc_seq.sv
// Multi-cycle sequencer for the RV core: FETCH/DECODE/EXEC/MEM/WB flow with
// ready/ack memory handshakes, a per-wait bus timeout, sticky halt/error
// states and saturating cycle/retired-instruction counters.
module rv_mc_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              TIMEOUT  = 16,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  rv_mc_seq_if.master      bus,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  pc_next,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             reg_write,
  output logic             rf_we,
  output logic             exit,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // The wait counter only ever holds 0..TIMEOUT-1: the cycle that would
  // reach TIMEOUT leaves the waiting state instead.
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       instr_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   npc_r;
  logic [WAIT_W-1:0] wait_r;
  logic [CNT_W-1:0]  cycle_r;
  logic [CNT_W-1:0]  instret_r;
  logic              waiting_s;
  logic              ack_s;
  logic              timeout_s;

  // Handshake qualification: an ack only counts in the state that requested it.
  always_comb begin
    waiting_s = (state_r == S_FETCH) || (state_r == S_MEM);
    ack_s     = ((state_r == S_FETCH) && bus.imem_ack) ||
                ((state_r == S_MEM)   && bus.dmem_ack);
    timeout_s = waiting_s && !ack_s && (wait_r == WAIT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic; an ack on the last allowed wait cycle beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (bus.imem_ack) begin
          if (bus.imem_rdata == 32'h0) state_nxt_s = S_HALT;
          else                         state_nxt_s = S_DECODE;
        end else if (timeout_s) begin
          state_nxt_s = S_ERROR;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC: begin
        if (is_load || is_store) state_nxt_s = S_MEM;
        else                     state_nxt_s = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ack)   state_nxt_s = S_WB;
        else if (timeout_s) state_nxt_s = S_ERROR;
        else                state_nxt_s = S_MEM;
      end
      S_WB:    state_nxt_s = S_FETCH;
      S_HALT:  state_nxt_s = S_HALT;
      S_ERROR: state_nxt_s = S_ERROR;
      default: state_nxt_s = S_ERROR;
    endcase
  end

  // FSM outputs decoded from the state register; reset forces requests low at once.
  always_comb begin
    bus.imem_req = !rst && (state_r == S_FETCH);
    bus.dmem_req = !rst && (state_r == S_MEM);
    bus.dmem_we  = !rst && (state_r == S_MEM) && is_store;
    rf_we        = !rst && (state_r == S_WB) && reg_write;
    exit         = (state_r == S_HALT);
    err          = (state_r == S_ERROR);
  end

  // Architectural registers: IR captured on fetch ack, next PC in EXEC, PC in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      instr_r <= 32'h0;
      npc_r   <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: if (bus.imem_ack) instr_r <= bus.imem_rdata;
        S_EXEC:  npc_r <= pc_next;
        S_WB:    pc_r  <= npc_r;
        default: ;
      endcase
    end
  end

  // Wait counter: counts unacked FETCH/MEM cycles, clears on ack or state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (waiting_s && !ack_s && (state_nxt_s == state_r)) begin
      wait_r <= wait_r + WAIT_W'(1);
    end else begin
      wait_r <= {WAIT_W{1'b0}};
    end
  end

  // Saturating performance counters; both stop in HALT/ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_r   <= {CNT_W{1'b0}};
      instret_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != S_HALT) && (state_r != S_ERROR) && (cycle_r != CNT_MAX))
        cycle_r <= cycle_r + CNT_W'(1);
      if ((state_r == S_WB) && (instret_r != CNT_MAX))
        instret_r <= instret_r + CNT_W'(1);
    end
  end

  assign bus.imem_addr = pc_r;
  assign instr         = instr_r;
  assign pc            = pc_r;
  assign state         = state_r;
  assign cycle_cnt     = cycle_r;
  assign instret_cnt   = instret_r;

endmodule

// File: tb/tb_rv_mc_seq.sv
// Self-checking bench for rv_mc_seq: random programs and memory latencies,
// a program-level reference model feeding a scoreboard of retirements, and
// directed reset/halt/timeout/abort scenarios.
module tb_rv_mc_seq;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        is_load, is_store, reg_write;
  logic        rf_we, exit, err;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  rv_mc_seq_if #(.XLEN(32)) bus_if ();

  rv_mc_seq #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .instr(instr), .pc(pc), .pc_next(pc_next),
    .is_load(is_load), .is_store(is_store), .reg_write(reg_write),
    .rf_we(rf_we), .exit(exit), .err(err), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational control and branch units, driven from IR/PC.
  always_comb begin
    is_load   = (instr[6:0] == 7'h03);
    is_store  = (instr[6:0] == 7'h23);
    reg_write = !is_store && (instr[11:7] != 5'd0);
    pc_next   = pc + (((instr[6:0] == 7'h6f) && instr[20]) ? 32'd8 : 32'd4);
  end

  // Program image with its generation metadata (type 0 alu,1 load,2 store,3 jal).
  logic [31:0] prog [64];
  int          ty   [64];
  logic [4:0]  rdv  [64];
  bit          skp  [64];
  int          flat [64];   // fetch wait cycles of the k-th dynamic instruction
  int          dlat [64];   // data wait cycles of the k-th dynamic instruction

  typedef struct {
    logic [31:0] pc;
    logic        rfwe;
    int          iret;
    int          cyc;
    int          dreq;
    logic        dwe;
  } rec_t;
  rec_t exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_end, exp_cyc, exp_iret;
  logic [31:0] exp_pc, exp_instr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: walk the program, summing per-phase cycle costs.
  task automatic model();
    logic [31:0] p;
    logic [31:0] w;
    int cyc, ret, idx;
    bit mem;
    rec_t r;
    p = 32'h0; cyc = 0; ret = 0; exp_instr = 32'h0; exp_end = 5;
    for (int k = 0; k < 64; k++) begin
      idx = int'(p[7:2]);
      if (flat[k] >= TMO) begin cyc += TMO; exp_end = 6; break; end
      cyc += flat[k] + 1;
      w = prog[idx];
      exp_instr = w;
      if (w == 32'h0) begin exp_end = 5; break; end
      cyc += 2;
      mem = (ty[idx] == 1) || (ty[idx] == 2);
      if (mem) begin
        if (dlat[k] >= TMO) begin cyc += TMO; exp_end = 6; break; end
        cyc += dlat[k] + 1;
      end
      cyc += 1;
      r.pc   = p;
      r.rfwe = (ty[idx] != 2) && (rdv[idx] != 5'd0);
      r.iret = ret;
      r.cyc  = cyc - 1;
      r.dreq = mem ? dlat[k] + 1 : 0;
      r.dwe  = (ty[idx] == 2);
      exp_q.push_back(r);
      ret++;
      p = p + (((ty[idx] == 3) && skp[idx]) ? 32'd8 : 32'd4);
    end
    exp_pc = p; exp_cyc = cyc; exp_iret = ret;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      prog[i] = 32'h0; ty[i] = 0; rdv[i] = 5'd0; skp[i] = 1'b0;
      flat[i] = 0; dlat[i] = 0;
    end
  endtask

  task automatic gen_prog(input int n);
    logic [31:0] hi;
    logic [6:0]  opc;
    int t;
    clear_prog();
    for (int i = 0; i < 64; i++) begin
      flat[i] = $urandom_range(0, TMO - 1);
      dlat[i] = $urandom_range(0, TMO - 1);
    end
    for (int i = 0; i < n; i++) begin
      t  = $urandom_range(0, 3);
      hi = $urandom;
      case (t)
        0:       opc = 7'h13;
        1:       opc = 7'h03;
        2:       opc = 7'h23;
        default: opc = 7'h6f;
      endcase
      prog[i] = {hi[31:7], opc};
      ty[i]   = t;
      rdv[i]  = hi[11:7];
      skp[i]  = hi[20];
    end
  endtask

  // Memory slave: answers the k-th fetch/data request after its chosen wait,
  // and throws spurious acks at whichever memory is not being asked.
  int fi = 0, iw = 0, dw = 0;
  initial begin
    bus_if.imem_ack = 1'b0; bus_if.imem_rdata = 32'h0; bus_if.dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fi = 0; iw = 0; dw = 0;
        bus_if.imem_ack = 1'b0; bus_if.dmem_ack = 1'b0;
      end else begin
        if (bus_if.imem_req) begin
          if (iw == flat[fi % 64]) begin
            bus_if.imem_ack   = 1'b1;
            bus_if.imem_rdata = prog[int'(bus_if.imem_addr[7:2])];
            fi++; iw = 0;
          end else begin
            bus_if.imem_ack = 1'b0; bus_if.imem_rdata = $urandom; iw++;
          end
        end else begin
          iw = 0;
          bus_if.imem_ack   = 1'($urandom_range(0, 1));
          bus_if.imem_rdata = $urandom;
        end
        if (bus_if.dmem_req) begin
          if (dw == dlat[(fi + 63) % 64]) begin bus_if.dmem_ack = 1'b1; dw = 0; end
          else begin bus_if.dmem_ack = 1'b0; dw++; end
        end else begin
          dw = 0;
          bus_if.dmem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pops one expected retirement every WB cycle.
  rec_t mon_r;
  int   mon_dcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      mon_dcnt = 0;
    end else begin
      if (bus_if.dmem_req) begin
        mon_dcnt++;
        if (exp_q.size() > 0) chk("dmem_we", bus_if.dmem_we, exp_q[0].dwe);
      end
      if (state == 3'd4) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected_pc", pc, 64'hffffffffffffffff);
        end else begin
          mon_r = exp_q.pop_front();
          chk("wb_pc", pc, mon_r.pc);
          chk("wb_rf_we", rf_we, mon_r.rfwe);
          chk("wb_instret", instret_cnt, mon_r.iret);
          chk("wb_cycle", cycle_cnt, mon_r.cyc);
          chk("wb_dreq_cycles", mon_dcnt, mon_r.dreq);
        end
        mon_dcnt = 0;
      end else begin
        chk("rf_we_outside_wb", rf_we, 1'b0);
      end
    end
  end

  // Reset, run the current program to HALT/ERROR, and check the final state.
  task automatic run_phase();
    @(negedge clk); #1 rst = 1'b1;
    exp_q.delete();
    model();
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imem_req", bus_if.imem_req, 1'b0);
    chk("rst_dmem_req", bus_if.dmem_req, 1'b0);
    chk("rst_dmem_we", bus_if.dmem_we, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_exit", exit, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cycle", cycle_cnt, 32'h0);
    chk("rst_instret", instret_cnt, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("first_imem_req", bus_if.imem_req, 1'b1);
    chk("first_imem_addr", bus_if.imem_addr, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      if ((state == 3'd5) || (state == 3'd6)) break;
      @(negedge clk);
    end
    chk("end_state", state, exp_end);
    chk("end_exit", exit, exp_end == 5);
    chk("end_err", err, exp_end == 6);
    chk("end_pc", pc, exp_pc);
    chk("end_instr", instr, exp_instr);
    chk("end_cycle", cycle_cnt, exp_cyc);
    chk("end_instret", instret_cnt, exp_iret);
    repeat (3) begin
      @(negedge clk);
      chk("frozen_imem_req", bus_if.imem_req, 1'b0);
      chk("frozen_dmem_req", bus_if.dmem_req, 1'b0);
      chk("frozen_cycle", cycle_cnt, exp_cyc);
      chk("frozen_pc", pc, exp_pc);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // addi, then a load with 3 extra data waits, then a zero word at pc=8.
    clear_prog();
    prog[0] = 32'h00500093; ty[0] = 0; rdv[0] = 5'd1;
    prog[1] = 32'h00002083; ty[1] = 1; rdv[1] = 5'd1;
    dlat[1] = 3;
    run_phase();

    // Fetch never acked: timeout to ERROR.
    clear_prog();
    prog[0] = 32'h00500093; ty[0] = 0; rdv[0] = 5'd1;
    flat[0] = 1000;
    run_phase();

    // Fetch acked on the last allowed cycle: normal flow, then halt at pc=4.
    flat[0] = TMO - 1;
    run_phase();

    // Random programs with random latencies; the first one starts with a store.
    for (int it = 0; it < 3; it++) begin
      gen_prog(24);
      if (it == 0) begin
        prog[0] = {prog[0][31:7], 7'h23};
        ty[0]   = 2;
      end
      run_phase();
    end

    // Reset asserted mid-MEM: requests drop at once, then a clean rerun.
    clear_prog();
    prog[0] = 32'h00002083; ty[0] = 1; rdv[0] = 5'd1;
    dlat[0] = 3;
    @(negedge clk); #1 rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.dmem_req) break;
    end
    chk("abort_in_mem", bus_if.dmem_req, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_dmem_req", bus_if.dmem_req, 1'b0);
    chk("abort_dmem_we", bus_if.dmem_we, 1'b0);
    chk("abort_state", state, 3'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_cycle", cycle_cnt, 32'h0);
    chk("abort_instret", instret_cnt, 32'h0);
    run_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_mc_seq.md
Name: rv_mc_seq

Overview:
- Parametrised multi-cycle sequencer for the RV core.
- Replaces the single-cycle top's implicit one-instruction-per-clock flow with an explicit FSM: FETCH, DECODE, EXEC, MEM, WB.
- Uses ready/ack handshakes to instruction and data memory, which allows multi-cycle memories.
- Owns PC, IR, halt/error status and performance counters. Existing decode/control, ALU, memory-access and branch units stay combinational and are driven from its IR/PC outputs and write enables.

Parameters:
- XLEN, 32: PC/address width.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 16: max wait cycles for a memory ack before the error state; must be >= 1.
- CNT_W, 32: width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  instruction register (IR).
- pc  out  XLEN  current PC.
- pc_next  in  XLEN  next PC from the branch unit (pc+4 or target).
- is_load  in  1  decoded load, from the control unit.
- is_store  in  1  decoded store, from the control unit.
- reg_write  in  1  decoded register write, from the control unit.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a write.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write enable.
- exit  out  1  sticky halt flag.
- err  out  1  sticky bus-timeout flag.
- state  out  3  encoded FSM state, for debug.
- cycle_cnt  out  CNT_W  active cycle count.
- instret_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Reset (async, rst=1):
  - state=FETCH(0); pc=RESET_PC; instr=0; npc=0; wait counter=0.
  - All req/we outputs 0; exit=0; err=0; both counters 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6.
- FETCH:
  - imem_req=1, held until imem_ack.
  - On ack: instr<=imem_rdata.
  - If imem_rdata==32'h0, go to HALT; otherwise go to DECODE.
- DECODE: one cycle; no outputs asserted; lets the control unit settle.
- EXEC:
  - One cycle; npc<=pc_next.
  - If is_load|is_store, go to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1; dmem_we=is_store; both held until dmem_ack, then go to WB.
  - is_load and is_store both 1: treated as a store.
- WB:
  - One cycle; rf_we=reg_write (combinational, WB only); pc<=npc; instret_cnt+=1; go to FETCH.
- HALT: absorbing; exit=1; no requests; pc and instr frozen.
- ERROR: absorbing; err=1; no requests; pc and instr frozen. Only rst leaves HALT or ERROR.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle without ack and clears on ack or state change.
  - When it reaches TIMEOUT without ack, the next state is ERROR and the request drops.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal transition.
- Latency: a non-memory instruction takes 4 cycles with a 1-cycle fetch ack (FETCH, DECODE, EXEC, WB). A load/store takes 5 cycles plus extra wait cycles.
- Counters:
  - cycle_cnt increments every cycle not in HALT/ERROR.
  - Both counters saturate at all-ones; they never wrap.
- pc arithmetic: modulo 2^XLEN; a wrap from npc is passed through unchecked.
- Acks in states with no request are ignored.
- Reset asserted mid-transaction aborts immediately: requests drop asynchronously.

Test Plan:
- Reset release, imem returns 32'h00500093 (addi x1,x0,5) with ack on the first cycle, pc_next=4, reg_write=1 -> states 0,1,2,4; rf_we high one cycle in WB; pc=4; instret_cnt=1; cycle_cnt=4.
- Load (is_load=1, reg_write=1), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; dmem_we=0; rf_we in WB; instruction takes 8 cycles total.
- Store (is_store=1, reg_write=0) -> dmem_we=1 while dmem_req; rf_we never asserted; instret increments.
- Fetch returns 32'h0 at pc=8 -> state=5; exit=1; imem_req=0 forever; cycle_cnt frozen; pc stays 8.
- TIMEOUT=4, imem_ack never asserted -> after 4 wait cycles state=6, err=1, imem_req=0. Repeat with ack on exactly the 4th cycle -> goes to DECODE, err=0.
- rst pulsed while in MEM with dmem_req=1 -> dmem_req=0 immediately; pc=RESET_PC; counters 0; fetch restarts.
